// File: rtl/operand_regfile.sv
// operand_regfile
//   Eight 16-bit operand registers with two combinational read ports, one
//   write port with write-through bypass, a 4-bit {S,Z,C,V} flag register and
//   a condition evaluator. After reset, an INIT phase clears every register
//   (one per cycle) before normal RUN operation is allowed.
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   synchronous, active-high reset
//   RA_ADDR    in   [2:0]  read port A index
//   RB_ADDR    in   [2:0]  read port B index
//   IMM_SEL    in   1 = DATA_B takes IMM
//   IMM        in   [15:0] immediate operand
//   WE         in   register write enable
//   W_ADDR     in   [2:0]  write index
//   W_DATA     in   [15:0] write data
//   FLAG_WE    in   flag register load enable
//   FLAG_IN    in   [3:0]  {S,Z,C,V}
//   COND       in   [2:0]  condition selector
//   DATA_A     out  [15:0] operand A
//   DATA_B     out  [15:0] operand B
//   FLAG_Q     out  [3:0]  registered flags {S,Z,C,V}
//   COND_TRUE  out  condition result
//   BUSY       out  high while the clear sequence runs (registered)
module operand_regfile (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  RA_ADDR,
  input  logic [2:0]  RB_ADDR,
  input  logic        IMM_SEL,
  input  logic [15:0] IMM,
  input  logic        WE,
  input  logic [2:0]  W_ADDR,
  input  logic [15:0] W_DATA,
  input  logic        FLAG_WE,
  input  logic [3:0]  FLAG_IN,
  input  logic [2:0]  COND,
  output logic [15:0] DATA_A,
  output logic [15:0] DATA_B,
  output logic [3:0]  FLAG_Q,
  output logic        COND_TRUE,
  output logic        BUSY
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  clr_ptr_q, clr_ptr_d;
  logic        busy_q, busy_d;
  logic [3:0]  flag_q, flag_d;
  logic [15:0] regs_q [8];

  logic        run;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        byp_a, byp_b;
  logic [15:0] rd_a, rd_b;
  logic        s_f, z_f, c_f, v_f;
  logic        cond_raw;

  // RST gates the outputs combinationally so a reset arriving in RUN
  // immediately hides operands and discards a same-cycle write.
  assign run = (state_q == RUN) && !RST;

  // Next-state logic for the INIT/RUN sequencer
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      INIT: begin
        clr_ptr_d = clr_ptr_q + 3'd1;
        if (clr_ptr_q == 3'd7) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    busy_d = (state_d == INIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= INIT;
      clr_ptr_q <= 3'd0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Write port is shared between the clear sequencer and the ALU result
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = W_ADDR;
    wr_data = W_DATA;
    if (!RST) begin
      if (state_q == INIT) begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_q;
        wr_data = 16'h0000;
      end else begin
        wr_en   = WE;
      end
    end
  end

  // Register storage has no reset; the INIT sweep defines its contents
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    flag_d = flag_q;
    if (run && FLAG_WE) begin
      flag_d = FLAG_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_q <= 4'b0000;
    end else begin
      flag_q <= flag_d;
    end
  end

  // Read ports with write-through bypass
  assign byp_a = run && WE && (W_ADDR == RA_ADDR);
  assign byp_b = run && WE && (W_ADDR == RB_ADDR);
  assign rd_a  = byp_a ? W_DATA : regs_q[RA_ADDR];
  assign rd_b  = byp_b ? W_DATA : regs_q[RB_ADDR];

  always_comb begin
    DATA_A = 16'h0000;
    DATA_B = 16'h0000;
    if (run) begin
      DATA_A = rd_a;
      DATA_B = IMM_SEL ? IMM : rd_b;
    end
  end

  // Condition evaluation from the registered flags
  assign {s_f, z_f, c_f, v_f} = flag_q;

  always_comb begin
    cond_raw = 1'b0;
    case (COND)
      3'd0: cond_raw = z_f;
      3'd1: cond_raw = !z_f;
      3'd2: cond_raw = s_f ^ v_f;
      3'd3: cond_raw = !(s_f ^ v_f);
      3'd4: cond_raw = c_f;
      3'd5: cond_raw = !c_f;
      3'd6: cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
  end

  assign COND_TRUE = run && cond_raw;
  assign FLAG_Q    = flag_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_operand_regfile.sv
module tb_operand_regfile;

  logic        CLK;
  logic        RST;
  logic [2:0]  RA_ADDR;
  logic [2:0]  RB_ADDR;
  logic        IMM_SEL;
  logic [15:0] IMM;
  logic        WE;
  logic [2:0]  W_ADDR;
  logic [15:0] W_DATA;
  logic        FLAG_WE;
  logic [3:0]  FLAG_IN;
  logic [2:0]  COND;
  logic [15:0] DATA_A;
  logic [15:0] DATA_B;
  logic [3:0]  FLAG_Q;
  logic        COND_TRUE;
  logic        BUSY;

  int n_cmp;
  int n_bad;

  operand_regfile dut (
    .CLK       (CLK),
    .RST       (RST),
    .RA_ADDR   (RA_ADDR),
    .RB_ADDR   (RB_ADDR),
    .IMM_SEL   (IMM_SEL),
    .IMM       (IMM),
    .WE        (WE),
    .W_ADDR    (W_ADDR),
    .W_DATA    (W_DATA),
    .FLAG_WE   (FLAG_WE),
    .FLAG_IN   (FLAG_IN),
    .COND      (COND),
    .DATA_A    (DATA_A),
    .DATA_B    (DATA_B),
    .FLAG_Q    (FLAG_Q),
    .COND_TRUE (COND_TRUE),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic        isel;
    logic [15:0] imm;
    logic        fwe;
    logic [3:0]  fin;
    logic [2:0]  cond;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [3:0]  exp_f;
    logic        exp_c;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic we, input logic [2:0] waddr,
                              input logic [15:0] wdata, input logic [2:0] ra,
                              input logic [2:0] rb, input logic isel,
                              input logic [15:0] imm, input logic fwe,
                              input logic [3:0] fin, input logic [2:0] cond,
                              input logic [15:0] exp_a, input logic [15:0] exp_b,
                              input logic [3:0] exp_f, input logic exp_c);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.ra = ra; v.rb = rb;
    v.isel = isel; v.imm = imm; v.fwe = fwe; v.fin = fin; v.cond = cond;
    v.exp_a = exp_a; v.exp_b = exp_b; v.exp_f = exp_f; v.exp_c = exp_c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; W_ADDR = 3'd0; W_DATA = 16'h0000;
    FLAG_WE = 1'b0; FLAG_IN = 4'h0;
    RA_ADDR = 3'd0; RB_ADDR = 3'd0; IMM_SEL = 1'b0; IMM = 16'h0000; COND = 3'd0;
  endtask

  // Counts BUSY-high cycles (bounded) while hammering writes that must be ignored
  task automatic run_clear(input string tag);
    int cnt;
    cnt = 0;
    WE = 1'b1; W_ADDR = 3'd5; W_DATA = 16'hAAAA;
    FLAG_WE = 1'b1; FLAG_IN = 4'hF;
    IMM_SEL = 1'b1; IMM = 16'hFFFF; COND = 3'd6; RA_ADDR = 3'd5; RB_ADDR = 3'd5;
    #1;
    while (BUSY === 1'b1 && cnt < 20) begin
      chk({tag, "_init_data_a"}, DATA_A, 16'h0000);
      chk({tag, "_init_data_b"}, DATA_B, 16'h0000);
      chk({tag, "_init_cond"}, {15'd0, COND_TRUE}, 16'h0000);
      chk({tag, "_init_flag"}, {12'd0, FLAG_Q}, 16'h0000);
      cnt++;
      tick();
    end
    idle_inputs();
    chk({tag, "_busy_cycles"}, cnt[15:0], 16'd8);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();

    // Reset held two cycles, operands must stay zero even with IMM selected
    RST = 1'b1;
    IMM_SEL = 1'b1; IMM = 16'hFFFF; COND = 3'd6;
    tick();
    tick();
    chk("rst_busy", {15'd0, BUSY}, 16'h0001);
    chk("rst_flag", {12'd0, FLAG_Q}, 16'h0000);
    chk("rst_data_a", DATA_A, 16'h0000);
    chk("rst_data_b", DATA_B, 16'h0000);
    chk("rst_cond", {15'd0, COND_TRUE}, 16'h0000);
    RST = 1'b0;
    run_clear("clr1");

    #1;
    chk("run_busy", {15'd0, BUSY}, 16'h0000);
    chk("run_flag_after_init", {12'd0, FLAG_Q}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      RA_ADDR = i[2:0];
      #1;
      chk($sformatf("cleared_reg%0d", i), DATA_A, 16'h0000);
    end

    // we wa wdata ra rb isel imm fwe fin cond | exp_a exp_b exp_f exp_c
    vecs[0]  = mk(1, 3, 16'hBEEF, 3, 3, 0, 16'h0000, 0, 4'h0, 0, 16'hBEEF, 16'hBEEF, 4'h0, 0);
    vecs[1]  = mk(0, 3, 16'h0000, 3, 3, 0, 16'h0000, 0, 4'h0, 7, 16'hBEEF, 16'hBEEF, 4'h0, 0);
    vecs[2]  = mk(1, 2, 16'h1234, 0, 2, 1, 16'h00FF, 0, 4'h0, 6, 16'h0000, 16'h00FF, 4'h0, 1);
    vecs[3]  = mk(0, 0, 16'h0000, 2, 2, 1, 16'h00FF, 0, 4'h0, 0, 16'h1234, 16'h00FF, 4'h0, 0);
    vecs[4]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h00FF, 1, 4'h8, 2, 16'hBEEF, 16'h1234, 4'h0, 0);
    vecs[5]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 2, 16'hBEEF, 16'h1234, 4'h8, 1);
    vecs[6]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 3, 16'hBEEF, 16'h1234, 4'h8, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 0, 16'hBEEF, 16'h1234, 4'h8, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 6, 16'hBEEF, 16'h1234, 4'h8, 1);
    vecs[9]  = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 1, 4'h4, 1, 16'hBEEF, 16'h1234, 4'h8, 1);
    vecs[10] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 0, 16'hBEEF, 16'h1234, 4'h4, 1);
    vecs[11] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 1, 4'h2, 4, 16'hBEEF, 16'h1234, 4'h4, 0);
    vecs[12] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 4, 16'hBEEF, 16'h1234, 4'h2, 1);
    vecs[13] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 1, 4'h1, 5, 16'hBEEF, 16'h1234, 4'h2, 0);
    vecs[14] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 2, 16'hBEEF, 16'h1234, 4'h1, 1);
    vecs[15] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 3, 16'hBEEF, 16'h1234, 4'h1, 0);
    vecs[16] = mk(0, 0, 16'h0000, 3, 2, 0, 16'h0000, 0, 4'h0, 7, 16'hBEEF, 16'h1234, 4'h1, 0);
    vecs[17] = mk(1, 7, 16'hFFFF, 7, 6, 0, 16'h0000, 0, 4'h0, 5, 16'hFFFF, 16'h0000, 4'h1, 1);
    vecs[18] = mk(1, 6, 16'h8001, 7, 6, 0, 16'h0000, 0, 4'h0, 0, 16'hFFFF, 16'h8001, 4'h1, 0);
    vecs[19] = mk(0, 0, 16'h0000, 6, 7, 0, 16'h0000, 0, 4'h0, 0, 16'h8001, 16'hFFFF, 4'h1, 0);
    vecs[20] = mk(1, 3, 16'h1111, 3, 3, 0, 16'h0000, 0, 4'h0, 0, 16'h1111, 16'h1111, 4'h1, 0);
    vecs[21] = mk(0, 0, 16'h0000, 3, 3, 0, 16'h0000, 0, 4'h0, 0, 16'h1111, 16'h1111, 4'h1, 0);

    for (int i = 0; i < 22; i++) begin
      WE = vecs[i].we; W_ADDR = vecs[i].waddr; W_DATA = vecs[i].wdata;
      RA_ADDR = vecs[i].ra; RB_ADDR = vecs[i].rb;
      IMM_SEL = vecs[i].isel; IMM = vecs[i].imm;
      FLAG_WE = vecs[i].fwe; FLAG_IN = vecs[i].fin; COND = vecs[i].cond;
      #1;
      chk($sformatf("vec%0d_data_a", i), DATA_A, vecs[i].exp_a);
      chk($sformatf("vec%0d_data_b", i), DATA_B, vecs[i].exp_b);
      chk($sformatf("vec%0d_flag", i), {12'd0, FLAG_Q}, {12'd0, vecs[i].exp_f});
      chk($sformatf("vec%0d_cond", i), {15'd0, COND_TRUE}, {15'd0, vecs[i].exp_c});
      tick();
    end
    idle_inputs();

    // Reset in the middle of RUN: register 1 and flags must be wiped
    WE = 1'b1; W_ADDR = 3'd1; W_DATA = 16'h5555;
    FLAG_WE = 1'b1; FLAG_IN = 4'hF;
    tick();
    idle_inputs();
    RA_ADDR = 3'd1;
    #1;
    chk("mid_reg1_written", DATA_A, 16'h5555);
    chk("mid_flag_loaded", {12'd0, FLAG_Q}, 16'h000F);
    RST = 1'b1;
    WE = 1'b1; W_ADDR = 3'd1; W_DATA = 16'h7777;
    FLAG_WE = 1'b1; FLAG_IN = 4'hA;
    #1;
    chk("mid_rst_data_a", DATA_A, 16'h0000);
    chk("mid_rst_cond", {15'd0, COND_TRUE}, 16'h0000);
    tick();
    RST = 1'b0;
    idle_inputs();
    #1;
    chk("mid_rst_flag", {12'd0, FLAG_Q}, 16'h0000);
    chk("mid_rst_busy", {15'd0, BUSY}, 16'h0001);
    run_clear("clr2");
    RA_ADDR = 3'd1; RB_ADDR = 3'd1;
    #1;
    chk("mid_reg1_cleared_a", DATA_A, 16'h0000);
    chk("mid_reg1_cleared_b", DATA_B, 16'h0000);
    chk("mid_flag_after", {12'd0, FLAG_Q}, 16'h0000);
    RA_ADDR = 3'd3;
    #1;
    chk("mid_reg3_cleared", DATA_A, 16'h0000);
    COND = 3'd6;
    #1;
    chk("mid_cond_al", {15'd0, COND_TRUE}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_regfile.md
OPERAND_REGFILE -- requirements
Module: operand_regfile

Interface
REQ-001 The block SHALL have no parameters; it SHALL hold 8 registers of 16 bits and one 4-bit flag register.
REQ-002 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 RA_ADDR  input  3  read-port A register index.
REQ-005 RB_ADDR  input  3  read-port B register index.
REQ-006 IMM_SEL  input  1  1 = DATA_B sourced from IMM instead of register file.
REQ-007 IMM  input  16  immediate operand.
REQ-008 WE  input  1  register write enable.
REQ-009 W_ADDR  input  3  write register index.
REQ-010 W_DATA  input  16  write data (ALU result).
REQ-011 FLAG_WE  input  1  flag register load enable.
REQ-012 FLAG_IN  input  4  flags {S,Z,C,V} from ALU.
REQ-013 COND  input  3  condition selector.
REQ-014 DATA_A  output  16  operand A to ALU.
REQ-015 DATA_B  output  16  operand B to ALU.
REQ-016 FLAG_Q  output  4  registered flags {S,Z,C,V}.
REQ-017 COND_TRUE  output  1  condition result.
REQ-018 BUSY  output  1  1 while the clear sequence runs.

Function
REQ-019 The block SHALL have two states, INIT and RUN, plus a 3-bit clear pointer CLR_PTR.
REQ-020 INIT: each cycle, write 16'h0000 to register CLR_PTR, then increment CLR_PTR. After CLR_PTR=7 is written, move to RUN. The sequence lasts 8 cycles after RST falls.
REQ-021 BUSY SHALL be 1 in INIT and 0 in RUN; it is a registered output.
REQ-022 In INIT, WE and FLAG_WE SHALL be ignored, and DATA_A and DATA_B SHALL be forced to 16'h0000, including when IMM_SEL=1.
REQ-023 In RUN with WE=1, W_DATA SHALL be written to register W_ADDR at the clock edge.
REQ-024 DATA_A SHALL be a combinational read of register RA_ADDR.
REQ-025 Write-through bypass: in RUN with WE=1 and W_ADDR=RA_ADDR, DATA_A SHALL equal W_DATA in the same cycle.
REQ-026 DATA_B SHALL equal IMM when IMM_SEL=1.
REQ-027 When IMM_SEL=0, DATA_B SHALL be the register read of RB_ADDR, with the same bypass rule as REQ-025.
REQ-028 Both read ports SHALL be able to address the same register, and both SHALL bypass simultaneously.
REQ-029 In RUN with FLAG_WE=1, FLAG_Q SHALL load FLAG_IN at the clock edge. FLAG_Q SHALL otherwise hold.
REQ-030 FLAG_Q has no bypass: a FLAG_WE in cycle N is visible on FLAG_Q and COND_TRUE from cycle N+1.
REQ-031 COND_TRUE SHALL be combinational from FLAG_Q and COND, with {S,Z,C,V}=FLAG_Q[3:0]:
  0 EQ = Z
  1 NE = !Z
  2 LT = S^V
  3 GE = !(S^V)
  4 CS = C
  5 CC = !C
  6 AL = 1
  7 NV = 0
REQ-032 In INIT, COND_TRUE SHALL be 0 regardless of COND.
REQ-033 Write to W_ADDR and read of the same register in the next cycle SHALL return the written value. There SHALL be no stall or hazard logic beyond the bypass.

Reset
REQ-034 While RST=1:
  - state SHALL be INIT, CLR_PTR=0, BUSY=1
  - FLAG_Q=4'b0000, DATA_A=DATA_B=16'h0000, COND_TRUE=0
REQ-035 RST asserted mid-INIT or mid-RUN SHALL restart the 8-cycle clear from register 0. A write pending in the same cycle as RST SHALL be discarded.
REQ-036 Register contents SHALL be undefined only until the clear sequence writes them; no register SHALL be readable in RUN without having been cleared or written.

Verification
REQ-037 Clear sequence: RST high 2 cycles, then low.
  - Required: BUSY=1 for exactly 8 cycles, then 0.
  - Then every RA_ADDR 0..7 reads 16'h0000.
REQ-038 Write and bypass: in RUN, WE=1, W_ADDR=3, W_DATA=16'hBEEF, RA_ADDR=RB_ADDR=3, IMM_SEL=0.
  - Required: DATA_A=DATA_B=16'hBEEF in the same cycle and in the next cycle with WE=0.
REQ-039 Immediate select: register 2 = 16'h1234, RB_ADDR=2, IMM=16'h00FF, IMM_SEL=1.
  - Required: DATA_B=16'h00FF.
  - With IMM_SEL=0: DATA_B=16'h1234.
REQ-040 Flags and conditions: FLAG_WE=1, FLAG_IN=4'b1000 (S=1, V=0).
  - Required next cycle: FLAG_Q=4'b1000; COND=2 gives COND_TRUE=1; COND=3 gives 0; COND=0 gives 0; COND=6 gives 1.
  - Same cycle as the load: FLAG_Q still holds the previous value.
REQ-041 Writes ignored in INIT: WE=1, W_ADDR=5, W_DATA=16'hAAAA and FLAG_WE=1, FLAG_IN=4'hF during INIT.
  - Required after RUN: register 5 reads 16'h0000, FLAG_Q=4'b0000.
REQ-042 Reset mid-RUN: write register 1 = 16'h5555, FLAG_Q=4'hF, then RST for 1 cycle.
  - Required: BUSY=1 for 8 cycles, FLAG_Q=0, register 1 reads 16'h0000 after the clear.
